prefetch_unit: RTL and testbench
================================

Name: prefetch_unit

Overview:
Parametrised instruction-fetch front end for the multicycle RV32 core. It replaces the single-word fetch path: it issues word reads on the shared memory handshake, buffers up to DEPTH fetched words (with their PCs) in a queue, and hands them to the control/decode stage with a valid/ready pair. It sits between the instruction counter/control logic and the memory block, and yields to data-phase accesses through mem_hold.

Parameters:
PC_WIDTH, 16, width of program counter and fetch address (wraps modulo 2^PC_WIDTH)
DEPTH, 2, instruction queue entries (power of two, >=1)
RESET_PC, 0, fetch address after reset (word aligned)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
mem_hold  input  1  data phase owns memory; no new fetch may be issued
mem_busy  input  1  memory block busy
mem_valid  input  1  one-cycle pulse, mem_rdata valid
mem_rdata  input  32  read data from memory block
fetch_ce  output  1  one-cycle fetch request strobe
fetch_addr  output  PC_WIDTH  fetch address, equals internal fetch_pc
iq_valid  output  1  queue head valid
iq_iword  output  32  queue head instruction word
iq_pc  output  PC_WIDTH  PC of queue head
iq_ready  input  1  consumer pops head when iq_valid && iq_ready
redirect  input  1  jump/branch/trap/mret: flush and refetch
redirect_pc  input  PC_WIDTH  new fetch target
pc_misaligned  output  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset is synchronous, active-low (reset == 0), on clk: state IDLE, fetch_pc = RESET_PC, queue count = 0, fetch_ce = 0, iq_valid = 0, pc_misaligned = 0, discard flag cleared.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE: issue when !mem_hold && !mem_busy && !redirect && count < DEPTH. On issue: fetch_ce = 1 for exactly one cycle, req_pc <= fetch_pc, go to WAIT. mem_valid in IDLE is ignored; this covers stale responses after reset.
- WAIT: fetch_ce = 0. On mem_valid, push {req_pc, mem_rdata}, fetch_pc <= fetch_pc + 4, go to IDLE. Next issue is no earlier than the following cycle.
- DRAIN: on mem_valid, drop the word, go to IDLE. fetch_pc is not incremented.
- Issue condition counts the in-flight word: at most one request outstanding, and only issued when a slot is free, so a push never overflows.
- Latency: mem_valid at cycle N gives iq_valid at cycle N+1 (registered queue).
- Queue: circular buffer, head/tail pointers wrap at DEPTH. Simultaneous push and pop when full or empty is legal: count unchanged when full; when empty, data passes through next cycle.
- iq_iword and iq_pc are stable while iq_valid && !iq_ready.
- Redirect (priority over everything except reset):
  - count <= 0 and iq_valid = 0 next cycle.
  - fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - From WAIT, go to DRAIN. From DRAIN, stay in DRAIN. From IDLE, stay in IDLE with no issue that cycle.
  - A redirect in the same cycle as mem_valid in WAIT drops that word and goes to IDLE.
  - Any push or pop in the redirect cycle is discarded.
- pc_misaligned = 1 for one cycle, registered, the cycle after a redirect with redirect_pc[1:0] != 0. Fetch continues from the aligned address.
- fetch_pc + 4 wraps modulo 2^PC_WIDTH, so the word after 0xFFFC is 0x0000 for PC_WIDTH = 16.
- mem_hold only blocks issue. An outstanding fetch still completes.

Optional Feature:
PREFETCH_BYPASS_EN. When defined, a word arriving on mem_valid in WAIT with an empty queue and no redirect is presented combinationally the same cycle: iq_valid = 1, iq_iword = mem_rdata, iq_pc = req_pc. If iq_ready is high, the word is consumed and not pushed; otherwise it is pushed as normal. Latency becomes 0 cycles for the empty-queue case. When not defined, all outputs come from the registered queue with 1-cycle latency.

Test Plan:
- Release reset, RESET_PC = 0, memory returns valid 2 cycles after ce, iq_ready = 1 -> fetch_ce addresses 0x0000, 0x0004, 0x0008; iq_pc/iq_iword match each word, with iq_valid one cycle after each mem_valid.
- iq_ready = 0, DEPTH = 2 -> exactly two fetches (0x0000, 0x0004), count stays 2, no third fetch_ce. Raise iq_ready for one cycle -> one pop, one new fetch at 0x0008.
- Redirect to 0x0040 while in WAIT for 0x0008 -> queue flushed, returning word dropped (no push), next fetch_ce at 0x0040, first iq_pc = 0x0040.
- Redirect to 0x0042 -> pc_misaligned pulses once, next fetch_ce addresses 0x0040.
- Redirect to 0xFFFC, PC_WIDTH = 16 -> fetches 0xFFFC then 0x0000.
- mem_hold = 1 during IDLE -> fetch_ce stays 0. Drop mem_hold -> fetch issues the next cycle. Assert reset during WAIT -> outputs return to reset values, late mem_valid ignored, next fetch_ce at RESET_PC.

Source files
------------

// File: rtl/prefetch_unit.sv
// prefetch_unit -- instruction-fetch front end for the multicycle RV32 core.
//
// Issues single-word reads on the shared memory handshake, buffers up to DEPTH
// fetched words together with their PCs, and presents the oldest one to the
// decode stage through a valid/ready pair. Fetching yields to data-phase
// accesses via mem_hold. At most one read is ever outstanding, and a read is
// only issued when a queue slot is free, so a returning word always fits.
//
// Optional build macro: PREFETCH_BYPASS_EN
//   defined   : a word returning into an empty queue is shown on the iq_*
//               outputs in the same cycle (zero latency); it is queued only
//               if the consumer does not take it.
//   undefined : iq_* outputs always come from the registered queue
//               (one cycle after mem_valid).
//
// Ports:
//   clk            clock
//   reset          synchronous, active-low reset
//   mem_hold       data phase owns memory, blocks new fetches
//   mem_busy       memory block busy, blocks new fetches
//   mem_valid      one-cycle pulse, mem_rdata valid
//   mem_rdata      read data from memory block
//   fetch_ce       one-cycle fetch request strobe
//   fetch_addr     fetch address (current fetch PC)
//   iq_valid       queue head valid
//   iq_iword       queue head instruction word
//   iq_pc          PC of queue head
//   iq_ready       consumer pops head when iq_valid && iq_ready
//   redirect       flush queue and refetch from redirect_pc
//   redirect_pc    new fetch target
//   pc_misaligned  one-cycle pulse after a redirect to a non-word address
//
// State | meaning
// IDLE  | no read outstanding; issue when memory is free and a slot is open
// WAIT  | read outstanding; its word will be queued
// DRAIN | read outstanding but flushed by a redirect; its word is dropped

module prefetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter int                  DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_hold,
  input  logic                mem_busy,
  input  logic                mem_valid,
  input  logic [31:0]         mem_rdata,
  output logic                fetch_ce,
  output logic [PC_WIDTH-1:0] fetch_addr,
  output logic                iq_valid,
  output logic [31:0]         iq_iword,
  output logic [PC_WIDTH-1:0] iq_pc,
  input  logic                iq_ready,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                pc_misaligned
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic [31:0]         q_word [DEPTH];
  logic [PC_WIDTH-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic                issue;
  logic                accept;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Gating with reset keeps the strobe quiet while reset is held, before the
  // first clock edge has forced the state register.
  assign issue  = reset && (state == IDLE) && !mem_hold && !mem_busy &&
                  !redirect && (count < CNT_W'(DEPTH));
  assign accept = (state == WAIT) && mem_valid && !redirect;

  assign fetch_ce   = issue;
  assign fetch_addr = fetch_pc;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass   = accept && (count == '0);
  assign iq_valid = (count != '0) || bypass;
  assign iq_iword = bypass ? mem_rdata : q_word[head];
  assign iq_pc    = bypass ? req_pc    : q_pc[head];
  // A bypassed word taken by the consumer never enters the queue.
  assign push     = accept && !(bypass && iq_ready);
  assign pop      = (count != '0) && iq_ready && !redirect;
`else
  assign iq_valid = (count != '0);
  assign iq_iword = q_word[head];
  assign iq_pc    = q_pc[head];
  assign push     = accept;
  assign pop      = iq_valid && iq_ready && !redirect;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (issue) state_nxt = WAIT;
      end
      WAIT: begin
        // A response coinciding with a redirect is simply dropped here.
        if (mem_valid)     state_nxt = IDLE;
        else if (redirect) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (mem_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc      <= RESET_PC;
      req_pc        <= RESET_PC;
      pc_misaligned <= 1'b0;
    end else begin
      pc_misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      end else if (accept) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
      end
      if (issue) req_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_word[tail] <= mem_rdata;
      q_pc[tail]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_hold = 1'b0;
  logic        mem_busy = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        iq_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;

  logic        fetch_ce;
  logic [15:0] fetch_addr;
  logic        iq_valid;
  logic [31:0] iq_iword;
  logic [15:0] iq_pc;
  logic        pc_misaligned;

  int tests = 0;
  int fails = 0;

  // memory model: one outstanding read, data returned 2 cycles after fetch_ce
  int          pend = 0;
  logic [15:0] pend_addr = 16'h0;

  logic [15:0] ce_q[$];
  logic [15:0] pop_pc_q[$];
  logic [31:0] pop_word_q[$];

  logic        s_ce, s_iqv, s_mis, s_mv;
  logic [15:0] s_addr, s_iqpc;
  logic [31:0] s_iqword;

  prefetch_unit #(.PC_WIDTH(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_hold(mem_hold), .mem_busy(mem_busy),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .fetch_ce(fetch_ce),
    .fetch_addr(fetch_addr), .iq_valid(iq_valid), .iq_iword(iq_iword),
    .iq_pc(iq_pc), .iq_ready(iq_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc_misaligned(pc_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Samples the current cycle (inputs already applied), then moves to the next.
  task automatic step();
    #2;
    s_ce = fetch_ce; s_addr = fetch_addr; s_iqv = iq_valid; s_iqpc = iq_pc;
    s_iqword = iq_iword; s_mis = pc_misaligned; s_mv = mem_valid;
    if (fetch_ce) begin
      ce_q.push_back(fetch_addr);
      pend = 2;
      pend_addr = fetch_addr;
    end
    if (reset && iq_valid && iq_ready && !redirect) begin
      pop_pc_q.push_back(iq_pc);
      pop_word_q.push_back(iq_iword);
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    if (pend == 1) begin
      mem_valid = 1'b1;
      mem_rdata = {16'hC0DE, pend_addr};
    end
    if (pend > 0) pend--;
  endtask

  task automatic apply_reset();
    reset = 1'b0; redirect = 1'b0; mem_hold = 1'b0; mem_busy = 1'b0; iq_ready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    ce_q.delete(); pop_pc_q.delete(); pop_word_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    tests++; if (s_ce !== 1'b0) begin fails++; $display("FAIL reset_ce: got %b expected 0", s_ce); end
    tests++; if (s_iqv !== 1'b0) begin fails++; $display("FAIL reset_iqv: got %b expected 0", s_iqv); end
    tests++; if (s_mis !== 1'b0) begin fails++; $display("FAIL reset_mis: got %b expected 0", s_mis); end
    tests++; if (s_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h expected 0000", s_addr); end
    reset = 1'b1;
    step();
    tests++; if (s_ce !== 1'b1 || s_addr !== 16'h0000) begin
      fails++; $display("FAIL reset_first_fetch: got ce=%b addr=%h expected ce=1 addr=0000", s_ce, s_addr);
    end
  endtask

  task automatic test_stream();
    logic prev_mv;
    apply_reset();
    iq_ready = 1'b1;
    prev_mv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++; if (s_iqv !== prev_mv) begin
        fails++; $display("FAIL stream_latency[%0d]: got iq_valid=%b expected %b", i, s_iqv, prev_mv);
      end
      prev_mv = s_mv;
    end
    tests++; if (ce_q.size() < 3) begin
      fails++; $display("FAIL stream_ce_count: got %0d expected >=3", ce_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (ce_q[i] !== 16'(i * 4)) begin
          fails++; $display("FAIL stream_ce_addr[%0d]: got %h expected %h", i, ce_q[i], 16'(i * 4));
        end
      end
    end
    tests++; if (pop_pc_q.size() < 3) begin
      fails++; $display("FAIL stream_pop_count: got %0d expected >=3", pop_pc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (pop_pc_q[i] !== 16'(i * 4) || pop_word_q[i] !== {16'hC0DE, 16'(i * 4)}) begin
          fails++; $display("FAIL stream_pop[%0d]: got pc=%h word=%h expected pc=%h word=%h",
                            i, pop_pc_q[i], pop_word_q[i], 16'(i * 4), {16'hC0DE, 16'(i * 4)});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (12) step();
    tests++; if (ce_q.size() !== 2) begin
      fails++; $display("FAIL bp_ce_count: got %0d expected 2", ce_q.size());
    end else begin
      tests++; if (ce_q[0] !== 16'h0000 || ce_q[1] !== 16'h0004) begin
        fails++; $display("FAIL bp_ce_addr: got %h,%h expected 0000,0004", ce_q[0], ce_q[1]);
      end
    end
    tests++; if (s_iqv !== 1'b1 || s_iqpc !== 16'h0000) begin
      fails++; $display("FAIL bp_head_hold: got v=%b pc=%h expected v=1 pc=0000", s_iqv, s_iqpc);
    end
    iq_ready = 1'b1;
    step();
    iq_ready = 1'b0;
    tests++; if (s_ce !== 1'b0) begin fails++; $display("FAIL bp_full_no_ce: got %b expected 0", s_ce); end
    step();
    tests++; if (s_ce !== 1'b1 || s_addr !== 16'h0008) begin
      fails++; $display("FAIL bp_refill: got ce=%b addr=%h expected ce=1 addr=0008", s_ce, s_addr);
    end
    tests++; if (pop_pc_q.size() !== 1 || s_iqpc !== 16'h0004) begin
      fails++; $display("FAIL bp_one_pop: got pops=%0d head=%h expected pops=1 head=0004", pop_pc_q.size(), s_iqpc);
    end
  endtask

  task automatic test_redirect();
    bit found;
    apply_reset();
    repeat (8) step();
    iq_ready = 1'b1;
    step();
    iq_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (s_ce) found = 1;
    end
    tests++; if (!found || s_addr !== 16'h0008) begin
      fails++; $display("FAIL redir_setup: got found=%b addr=%h expected found=1 addr=0008", found, s_addr);
    end
    pop_pc_q.delete(); pop_word_q.delete();
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    tests++; if (s_iqv !== 1'b1 || s_iqpc !== 16'h0004) begin
      fails++; $display("FAIL redir_pre_head: got v=%b pc=%h expected v=1 pc=0004", s_iqv, s_iqpc);
    end
    step();
    tests++; if (s_iqv !== 1'b0 || s_ce !== 1'b0) begin
      fails++; $display("FAIL redir_flush: got v=%b ce=%b expected v=0 ce=0", s_iqv, s_ce);
    end
    step();
    tests++; if (s_ce !== 1'b1 || s_addr !== 16'h0040 || s_iqv !== 1'b0) begin
      fails++; $display("FAIL redir_refetch: got ce=%b addr=%h v=%b expected ce=1 addr=0040 v=0", s_ce, s_addr, s_iqv);
    end
    iq_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (s_iqv) found = 1;
    end
    tests++; if (!found || s_iqpc !== 16'h0040 || s_iqword !== 32'hC0DE0040) begin
      fails++; $display("FAIL redir_first_word: got found=%b pc=%h word=%h expected 1 0040 c0de0040", found, s_iqpc, s_iqword);
    end
  endtask

  task automatic test_misaligned();
    int pulses;
    apply_reset();
    iq_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0042;
    step();
    redirect = 1'b0;
    tests++; if (s_ce !== 1'b0 || s_mis !== 1'b0) begin
      fails++; $display("FAIL mis_redirect_cycle: got ce=%b mis=%b expected 0 0", s_ce, s_mis);
    end
    step();
    tests++; if (s_mis !== 1'b1) begin fails++; $display("FAIL mis_pulse: got %b expected 1", s_mis); end
    tests++; if (s_ce !== 1'b1 || s_addr !== 16'h0040) begin
      fails++; $display("FAIL mis_aligned_fetch: got ce=%b addr=%h expected ce=1 addr=0040", s_ce, s_addr);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_mis) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL mis_one_shot: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_wrap();
    apply_reset();
    iq_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    step();
    redirect = 1'b0;
    ce_q.delete(); pop_pc_q.delete(); pop_word_q.delete();
    repeat (12) step();
    tests++; if (ce_q.size() < 2) begin
      fails++; $display("FAIL wrap_ce_count: got %0d expected >=2", ce_q.size());
    end else begin
      tests++; if (ce_q[0] !== 16'hFFFC || ce_q[1] !== 16'h0000) begin
        fails++; $display("FAIL wrap_ce_addr: got %h,%h expected fffc,0000", ce_q[0], ce_q[1]);
      end
    end
    tests++; if (pop_pc_q.size() < 2) begin
      fails++; $display("FAIL wrap_pop_count: got %0d expected >=2", pop_pc_q.size());
    end else begin
      tests++; if (pop_pc_q[0] !== 16'hFFFC || pop_pc_q[1] !== 16'h0000 || pop_word_q[1] !== 32'hC0DE0000) begin
        fails++; $display("FAIL wrap_pop: got %h,%h word %h expected fffc,0000 word c0de0000",
                          pop_pc_q[0], pop_pc_q[1], pop_word_q[1]);
      end
    end
  endtask

  task automatic test_hold();
    bit found;
    apply_reset();
    mem_hold = 1'b1;
    repeat (4) step();
    tests++; if (ce_q.size() !== 0) begin fails++; $display("FAIL hold_blocks: got %0d fetches expected 0", ce_q.size()); end
    mem_hold = 1'b0; mem_busy = 1'b1;
    repeat (3) step();
    tests++; if (ce_q.size() !== 0) begin fails++; $display("FAIL busy_blocks: got %0d fetches expected 0", ce_q.size()); end
    mem_busy = 1'b0;
    step();
    tests++; if (s_ce !== 1'b1 || s_addr !== 16'h0000) begin
      fails++; $display("FAIL hold_release: got ce=%b addr=%h expected ce=1 addr=0000", s_ce, s_addr);
    end
    mem_hold = 1'b1; iq_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (s_iqv) found = 1;
    end
    tests++; if (!found || s_iqpc !== 16'h0000 || ce_q.size() !== 1) begin
      fails++; $display("FAIL hold_completes: got found=%b pc=%h fetches=%0d expected 1 0000 1", found, s_iqpc, ce_q.size());
    end
    mem_hold = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit found;
    apply_reset();
    iq_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    tests++; if (s_ce !== 1'b0) begin fails++; $display("FAIL rw_ce_in_reset: got %b expected 0", s_ce); end
    reset = 1'b1;
    step();
    tests++; if (s_ce !== 1'b1 || s_addr !== 16'h0000 || s_iqv !== 1'b0) begin
      fails++; $display("FAIL rw_restart: got ce=%b addr=%h v=%b expected ce=1 addr=0000 v=0", s_ce, s_addr, s_iqv);
    end
    step();
    tests++; if (s_iqv !== 1'b0) begin fails++; $display("FAIL rw_stale_ignored: got iq_valid=%b expected 0", s_iqv); end
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (s_iqv) found = 1;
    end
    tests++; if (!found || s_iqpc !== 16'h0000) begin
      fails++; $display("FAIL rw_new_word: got found=%b pc=%h expected 1 0000", found, s_iqpc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_hold();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
